// File: rtl/multicycle_sequencer_pkg.sv
// Shared types for the multi-cycle sequencer:
// FSM states, trap cause codes and PC source select.
package seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_FWAIT,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_MWAIT,
    S_WB,
    S_TRAP
  } state_t;

  localparam logic [3:0] CAUSE_IFAULT  = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_LFAULT  = 4'd5;
  localparam logic [3:0] CAUSE_SFAULT  = 4'd7;

  localparam logic PC_NEXT = 1'b0;
  localparam logic PC_TRAP = 1'b1;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction and data bus request/grant/response
// handshakes between sequencer (master) and bus.
interface multicycle_sequencer_if;

  logic imem_req;
  logic imem_gnt;
  logic imem_rvalid;
  logic dmem_req;
  logic dmem_we;
  logic dmem_gnt;
  logic dmem_rvalid;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_gnt,
    input  imem_rvalid,
    input  dmem_gnt,
    input  dmem_rvalid
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_gnt,
    output imem_rvalid,
    output dmem_gnt,
    output dmem_rvalid
  );

endinterface

// File: rtl/multicycle_sequencer_watchdog.sv
// Counts consecutive waiting cycles without the
// awaited bus event; flags expiry on the last one.
module bus_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic wait_en,
  input  logic evt,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  // the event wins over an expiry in the same cycle
  assign expire = wait_en & ~evt & (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (wait_en & ~evt) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb,
// bus handshakes, trap path and cycle/instret counters.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  multicycle_sequencer_if.master bus,
  input  logic                 dec_illegal,
  input  logic                 dec_load,
  input  logic                 dec_store,
  input  logic                 dec_rf_wb,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic                 rf_we,
  output logic                 trap,
  output logic [3:0]           trap_cause,
  output logic                 busy,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt
);

  state_t     state;
  state_t     nxt;
  logic       wait_en;
  logic       evt;
  logic       expire;
  logic [3:0] fault;

  always_comb begin
    wait_en = 1'b0;
    evt     = 1'b0;
    fault   = CAUSE_IFAULT;
    unique case (state)
      S_FETCH: begin
        wait_en = bus.imem_req;
        evt     = bus.imem_gnt;
      end
      S_FWAIT: begin
        wait_en = 1'b1;
        evt     = bus.imem_rvalid;
      end
      S_MEM: begin
        wait_en = 1'b1;
        evt     = bus.dmem_gnt;
        fault   = dec_store ? CAUSE_SFAULT
                            : CAUSE_LFAULT;
      end
      S_MWAIT: begin
        wait_en = 1'b1;
        evt     = bus.dmem_rvalid;
        fault   = dec_store ? CAUSE_SFAULT
                            : CAUSE_LFAULT;
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_FETCH:
        if (bus.imem_req & bus.imem_gnt)
          nxt = S_FWAIT;
      S_FWAIT:
        if (bus.imem_rvalid) nxt = S_DECODE;
      S_DECODE:
        nxt = dec_illegal ? S_TRAP : S_EXEC;
      S_EXEC:
        nxt = (dec_load | dec_store) ? S_MEM
                                     : S_WB;
      S_MEM:
        if (bus.dmem_gnt) nxt = S_MWAIT;
      S_MWAIT:
        if (bus.dmem_rvalid) nxt = S_WB;
      default:
        nxt = S_FETCH;
    endcase
    if (expire) nxt = S_TRAP;
  end

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (nxt != state),
    .wait_en (wait_en),
    .evt     (evt),
    .expire  (expire)
  );

  // IR must capture the word in the cycle rvalid is seen
  assign ir_we = (state == S_FWAIT) & bus.imem_rvalid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_FETCH;
      bus.imem_req <= 1'b0;
      bus.dmem_req <= 1'b0;
      bus.dmem_we  <= 1'b0;
      pc_we        <= 1'b0;
      pc_sel       <= PC_NEXT;
      rf_we        <= 1'b0;
      trap         <= 1'b0;
      trap_cause   <= '0;
      busy         <= 1'b0;
      cycle_cnt    <= '0;
      instret_cnt  <= '0;
    end else begin
      state        <= nxt;
      bus.imem_req <= (nxt == S_FETCH);
      bus.dmem_req <= (nxt == S_MEM);
      bus.dmem_we  <= (nxt == S_MEM) & dec_store;
      busy         <= (nxt != S_FETCH);
      pc_we        <= (nxt == S_WB) |
                      (nxt == S_TRAP);
      pc_sel       <= (nxt == S_TRAP) ? PC_TRAP
                                      : PC_NEXT;
      rf_we        <= (nxt == S_WB) & dec_rf_wb &
                      ~dec_store;
      trap         <= (nxt == S_TRAP);
      if (nxt == S_TRAP)
        trap_cause <= expire ? fault : CAUSE_ILLEGAL;
      cycle_cnt    <= cycle_cnt + 1'b1;
      if (state == S_WB)
        instret_cnt <= instret_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer with a
// reactive bus responder and a small counter model.
module tb_multicycle_sequencer;

  logic        clk;
  logic        rstn;
  logic        dec_illegal;
  logic        dec_load;
  logic        dec_store;
  logic        dec_rf_wb;
  logic        ir_we;
  logic        pc_we;
  logic        pc_sel;
  logic        rf_we;
  logic        trap;
  logic [3:0]  trap_cause;
  logic        busy;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  multicycle_sequencer_if bus ();

  multicycle_sequencer #(
    .TIMEOUT (4),
    .CNT_W   (64)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .dec_illegal (dec_illegal),
    .dec_load    (dec_load),
    .dec_store   (dec_store),
    .dec_rf_wb   (dec_rf_wb),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .rf_we       (rf_we),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .busy        (busy),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          ir_cyc;
    int          dreq;
    bit          dwe;
    bit          rf;
    bit          trp;
    bit          sel;
    logic [3:0]  cause;
    logic [63:0] instret;
    logic [63:0] cycle;
  } rec_t;

  rec_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [63:0] m_cyc;
  logic [63:0] m_inst;
  logic [3:0]  m_cause;

  // drives one instruction; igd/dgd = grant delay
  // in request cycles, cycle numbers start at 1
  task automatic run(input int igd, input int dgd,
                     input bit ld, input bit st,
                     input bit ill, input bit wb,
                     output rec_t o);
    int n, fc, dc;
    bit irv, drv;
    n = 0; fc = 0; dc = 0; irv = 0; drv = 0;
    o = '{default: 0};
    dec_load = ld; dec_store = st;
    dec_illegal = ill; dec_rf_wb = wb;
    while (n < 40) begin
      @(negedge clk);
      n++;
      bus.imem_gnt = 1'b0;
      bus.imem_rvalid = irv; irv = 0;
      bus.dmem_gnt = 1'b0;
      bus.dmem_rvalid = drv; drv = 0;
      if (bus.imem_req) begin
        if (fc == igd) begin
          bus.imem_gnt = 1'b1; irv = 1;
        end
        fc++;
      end
      if (bus.dmem_req) begin
        o.dreq++;
        if (bus.dmem_we) o.dwe = 1;
        if (dc == dgd) begin
          bus.dmem_gnt = 1'b1; drv = 1;
        end
        dc++;
      end
      #1;
      if (ir_we) o.ir_cyc = n;
      if (pc_we) begin
        o.cyc = n; o.rf = rf_we; o.trp = trap;
        o.sel = pc_sel; o.cause = trap_cause;
        break;
      end
    end
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
    @(posedge clk); #1;
    o.instret = instret_cnt;
    o.cycle = cycle_cnt;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    dec_illegal = 0; dec_load = 0;
    dec_store = 0; dec_rf_wb = 0;
    bus.imem_gnt = 0; bus.imem_rvalid = 0;
    bus.dmem_gnt = 0; bus.dmem_rvalid = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.imem_req, bus.dmem_req, bus.dmem_we,
         ir_we, pc_we, pc_sel, rf_we, trap,
         busy} !== 9'b0) begin
      bad++;
      $display("FAIL rst_outs got=%b exp=0",
        {bus.imem_req, bus.dmem_req, bus.dmem_we,
         ir_we, pc_we, pc_sel, rf_we, trap, busy});
    end
    total++;
    if ({trap_cause, cycle_cnt, instret_cnt} !== '0)
    begin
      bad++;
      $display("FAIL rst_cnt got=%0d/%0d/%0d exp=0",
        trap_cause, cycle_cnt, instret_cnt);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.imem_req !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_rel req/busy got=%b%b exp=10",
        bus.imem_req, busy);
    end
    total++;
    if (cycle_cnt !== 64'd1) begin
      bad++;
      $display("FAIL rst_cyc got=%0d exp=1", cycle_cnt);
    end
    m_cyc = 64'd1; m_inst = '0; m_cause = '0;
  endtask

  task automatic test_alu();
    rec_t o, e;
    sb.push_back('{cyc: 5, ir_cyc: 2, dreq: 0,
      dwe: 0, rf: 1, trp: 0, sel: 0,
      cause: m_cause, instret: m_inst + 64'd1,
      cycle: m_cyc + 64'd5});
    run(0, 0, 0, 0, 0, 1, o);
    e = sb.pop_front();
    total++;
    if (o.ir_cyc !== e.ir_cyc) begin
      bad++;
      $display("FAIL alu_ir got=%0d exp=%0d",
        o.ir_cyc, e.ir_cyc);
    end
    total++;
    if (o.cyc !== e.cyc || o.rf !== e.rf ||
        o.trp !== e.trp) begin
      bad++;
      $display("FAIL alu_wb got=%0d/%b/%b exp=%0d/%b/%b",
        o.cyc, o.rf, o.trp, e.cyc, e.rf, e.trp);
    end
    total++;
    if (o.instret !== e.instret ||
        o.cycle !== e.cycle) begin
      bad++;
      $display("FAIL alu_cnt got=%0d/%0d exp=%0d/%0d",
        o.instret, o.cycle, e.instret, e.cycle);
    end
    m_inst = e.instret; m_cyc = e.cycle;
  endtask

  task automatic test_load_gnt_delay();
    rec_t o, e;
    sb.push_back('{cyc: 10, ir_cyc: 2, dreq: 4,
      dwe: 0, rf: 1, trp: 0, sel: 0,
      cause: m_cause, instret: m_inst + 64'd1,
      cycle: m_cyc + 64'd10});
    run(0, 3, 1, 0, 0, 1, o);
    e = sb.pop_front();
    total++;
    if (o.dreq !== e.dreq || o.dwe !== e.dwe) begin
      bad++;
      $display("FAIL ld_req got=%0d/%b exp=%0d/%b",
        o.dreq, o.dwe, e.dreq, e.dwe);
    end
    total++;
    if (o.cyc !== e.cyc || o.rf !== e.rf ||
        o.trp !== e.trp) begin
      bad++;
      $display("FAIL ld_wb got=%0d/%b/%b exp=%0d/%b/%b",
        o.cyc, o.rf, o.trp, e.cyc, e.rf, e.trp);
    end
    total++;
    if (o.instret !== e.instret) begin
      bad++;
      $display("FAIL ld_inst got=%0d exp=%0d",
        o.instret, e.instret);
    end
    m_inst = e.instret; m_cyc = e.cycle;
  endtask

  task automatic test_store();
    rec_t o, e;
    sb.push_back('{cyc: 7, ir_cyc: 2, dreq: 1,
      dwe: 1, rf: 0, trp: 0, sel: 0,
      cause: m_cause, instret: m_inst + 64'd1,
      cycle: m_cyc + 64'd7});
    run(0, 0, 0, 1, 0, 1, o);
    e = sb.pop_front();
    total++;
    if (o.dreq !== e.dreq || o.dwe !== e.dwe) begin
      bad++;
      $display("FAIL st_req got=%0d/%b exp=%0d/%b",
        o.dreq, o.dwe, e.dreq, e.dwe);
    end
    total++;
    if (o.cyc !== e.cyc || o.rf !== e.rf) begin
      bad++;
      $display("FAIL st_wb got=%0d/%b exp=%0d/%b",
        o.cyc, o.rf, e.cyc, e.rf);
    end
    total++;
    if (o.cycle !== e.cycle) begin
      bad++;
      $display("FAIL st_cyc got=%0d exp=%0d",
        o.cycle, e.cycle);
    end
    m_inst = e.instret; m_cyc = e.cycle;
  endtask

  task automatic test_illegal();
    rec_t o, e;
    sb.push_back('{cyc: 4, ir_cyc: 2, dreq: 0,
      dwe: 0, rf: 0, trp: 1, sel: 1,
      cause: 4'd2, instret: m_inst,
      cycle: m_cyc + 64'd4});
    run(0, 0, 0, 0, 1, 1, o);
    e = sb.pop_front();
    total++;
    if (o.cyc !== e.cyc || o.trp !== e.trp ||
        o.sel !== e.sel || o.rf !== e.rf) begin
      bad++;
      $display("FAIL ill_trap got=%0d/%b/%b/%b exp=%0d/%b/%b/%b",
        o.cyc, o.trp, o.sel, o.rf,
        e.cyc, e.trp, e.sel, e.rf);
    end
    total++;
    if (o.cause !== e.cause ||
        o.instret !== e.instret) begin
      bad++;
      $display("FAIL ill_cause got=%0d/%0d exp=%0d/%0d",
        o.cause, o.instret, e.cause, e.instret);
    end
    m_cause = e.cause; m_cyc = e.cycle;
  endtask

  task automatic test_fetch_timeout();
    rec_t o, e;
    sb.push_back('{cyc: 5, ir_cyc: 0, dreq: 0,
      dwe: 0, rf: 0, trp: 1, sel: 1,
      cause: 4'd1, instret: m_inst,
      cycle: m_cyc + 64'd5});
    sb.push_back('{cyc: 8, ir_cyc: 5, dreq: 0,
      dwe: 0, rf: 1, trp: 0, sel: 0,
      cause: 4'd1, instret: m_inst + 64'd1,
      cycle: m_cyc + 64'd13});
    run(99, 0, 0, 0, 0, 1, o);
    e = sb.pop_front();
    total++;
    if (o.cyc !== e.cyc || o.trp !== e.trp ||
        o.cause !== e.cause || o.ir_cyc !== 0) begin
      bad++;
      $display("FAIL if_to got=%0d/%b/%0d/%0d exp=%0d/%b/%0d/0",
        o.cyc, o.trp, o.cause, o.ir_cyc,
        e.cyc, e.trp, e.cause);
    end
    total++;
    if (o.instret !== e.instret) begin
      bad++;
      $display("FAIL if_to_inst got=%0d exp=%0d",
        o.instret, e.instret);
    end
    run(3, 0, 0, 0, 0, 1, o);
    e = sb.pop_front();
    total++;
    if (o.cyc !== e.cyc || o.trp !== e.trp ||
        o.ir_cyc !== e.ir_cyc) begin
      bad++;
      $display("FAIL if_edge got=%0d/%b/%0d exp=%0d/%b/%0d",
        o.cyc, o.trp, o.ir_cyc,
        e.cyc, e.trp, e.ir_cyc);
    end
    total++;
    if (o.cause !== e.cause ||
        o.cycle !== e.cycle) begin
      bad++;
      $display("FAIL if_edge_hold got=%0d/%0d exp=%0d/%0d",
        o.cause, o.cycle, e.cause, e.cycle);
    end
    m_cause = e.cause; m_inst = e.instret;
    m_cyc = e.cycle;
  endtask

  task automatic test_data_fault();
    rec_t o, e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{cyc: 9, ir_cyc: 2, dreq: 4,
        dwe: (i == 0), rf: 0, trp: 1, sel: 1,
        cause: (i == 0) ? 4'd7 : 4'd5,
        instret: m_inst, cycle: m_cyc + 64'd9});
      run(0, 99, (i == 1), (i == 0), 0, 1, o);
      e = sb.pop_front();
      total++;
      if (o.cyc !== e.cyc || o.trp !== e.trp ||
          o.cause !== e.cause) begin
        bad++;
        $display("FAIL dfault%0d got=%0d/%b/%0d exp=%0d/%b/%0d",
          i, o.cyc, o.trp, o.cause,
          e.cyc, e.trp, e.cause);
      end
      total++;
      if (o.dreq !== e.dreq || o.dwe !== e.dwe ||
          o.instret !== e.instret) begin
        bad++;
        $display("FAIL dfault%0d_req got=%0d/%b/%0d exp=%0d/%b/%0d",
          i, o.dreq, o.dwe, o.instret,
          e.dreq, e.dwe, e.instret);
      end
      m_cause = e.cause; m_cyc = e.cycle;
    end
  endtask

  task automatic test_back_to_back();
    rec_t o, e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{cyc: 5, ir_cyc: 2, dreq: 0,
        dwe: 0, rf: (i == 1), trp: 0, sel: 0,
        cause: m_cause,
        instret: m_inst + 64'(i + 1),
        cycle: m_cyc + 64'(5 * (i + 1))});
    end
    for (int i = 0; i < 3; i++) begin
      run(0, 0, 0, 0, 0, (i == 1), o);
      e = sb.pop_front();
      total++;
      if (o.cyc !== e.cyc || o.rf !== e.rf ||
          o.instret !== e.instret ||
          o.cycle !== e.cycle) begin
        bad++;
        $display("FAIL b2b%0d got=%0d/%b/%0d/%0d exp=%0d/%b/%0d/%0d",
          i, o.cyc, o.rf, o.instret, o.cycle,
          e.cyc, e.rf, e.instret, e.cycle);
      end
      m_inst = e.instret; m_cyc = e.cycle;
    end
  endtask

  task automatic test_reset_mid();
    dec_load = 1; dec_store = 0;
    dec_illegal = 0; dec_rf_wb = 1;
    @(negedge clk); bus.imem_gnt = 1'b1;
    @(negedge clk); bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b1;
    @(negedge clk); bus.imem_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.dmem_req !== 1'b1) begin
      bad++;
      $display("FAIL mid_mem got=%b exp=1",
        bus.dmem_req);
    end
    bus.dmem_gnt = 1'b1;
    @(negedge clk); bus.dmem_gnt = 1'b0;
    rstn = 1'b0;
    #1;
    total++;
    if ({bus.imem_req, bus.dmem_req, bus.dmem_we,
         ir_we, pc_we, pc_sel, rf_we, trap,
         busy} !== 9'b0) begin
      bad++;
      $display("FAIL mid_outs got=%b exp=0",
        {bus.imem_req, bus.dmem_req, bus.dmem_we,
         ir_we, pc_we, pc_sel, rf_we, trap, busy});
    end
    total++;
    if ({trap_cause, cycle_cnt, instret_cnt} !== '0)
    begin
      bad++;
      $display("FAIL mid_cnt got=%0d/%0d/%0d exp=0",
        trap_cause, cycle_cnt, instret_cnt);
    end
    bus.dmem_rvalid = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b0;
    total++;
    if (bus.imem_req !== 1'b1 || busy !== 1'b0 ||
        bus.dmem_req !== 1'b0 || rf_we !== 1'b0) begin
      bad++;
      $display("FAIL mid_rel got=%b%b%b%b exp=1000",
        bus.imem_req, busy, bus.dmem_req, rf_we);
    end
    m_cyc = 64'd1; m_inst = '0; m_cause = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=done");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    test_reset();
    test_alu();
    test_load_gnt_delay();
    test_store();
    test_illegal();
    test_fetch_timeout();
    test_data_fault();
    test_back_to_back();
    test_reset_mid();
    test_alu();
    $display("test done: total=%0d bad=%0d",
      total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control FSM that sequences one instruction at a time through fetch, decode, execute, memory and writeback.
It drives the instruction/data bus handshakes, the IR/PC/register-file write enables and the trap path.
It consumes the per-instruction class flags produced by the combinational instruction decoder.
It sits between the bus interface and the datapath, and also keeps the cycle/instret counters.

Parameters:
TIMEOUT, 16, max cycles waiting for any gnt or rvalid before an access-fault trap (≥2)
CNT_W, 64, width of cycle and instret counters

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
imem_req  out  1  instruction fetch request
imem_gnt  in  1  fetch request accepted
imem_rvalid  in  1  fetch data valid (instruction itself goes straight to IR)
dmem_req  out  1  data access request
dmem_we  out  1  1=store, 0=load; valid while dmem_req
dmem_gnt  in  1  data request accepted
dmem_rvalid  in  1  data response/ack valid (loads and stores)
dec_illegal  in  1  decoder illegal flag
dec_load  in  1  instruction is a load
dec_store  in  1  instruction is a store
dec_rf_wb  in  1  instruction writes rd
ir_we  out  1  latch instruction register
pc_we  out  1  update PC
pc_sel  out  1  0=next/branch target, 1=trap vector
rf_we  out  1  register-file write enable
trap  out  1  one-cycle trap pulse
trap_cause  out  4  cause code, held until the next trap
busy  out  1  0 only in FETCH before imem_gnt
cycle_cnt  out  CNT_W  cycles since reset
instret_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (async, rstn=0):
  - state=FETCH; every 1-bit output 0; trap_cause=0; both counters 0; watchdog 0.
- States: FETCH, FWAIT, DECODE, EXEC, MEM, MWAIT, WB, TRAP.
- FETCH:
  - imem_req=1, held until imem_gnt (PC must not change meanwhile).
  - gnt -> FWAIT.
  - imem_rvalid is ignored here; the bus guarantees rvalid ≥1 cycle after gnt.
- FWAIT:
  - on imem_rvalid: ir_we=1 that cycle -> DECODE.
- DECODE:
  - dec_illegal -> TRAP with cause 2; else -> EXEC.
  - Decoder flags are sampled only from DECODE through WB; IR is stable then.
- EXEC:
  - one cycle; (dec_load|dec_store) -> MEM; else -> WB.
- MEM:
  - dmem_req=1, dmem_we=dec_store, held until dmem_gnt -> MWAIT.
- MWAIT:
  - on dmem_rvalid -> WB.
- WB:
  - rf_we = dec_rf_wb & ~dec_store; pc_we=1; pc_sel=0; instret_cnt+1 -> FETCH.
- TRAP:
  - trap=1, pc_we=1, pc_sel=1, trap_cause updated; instret unchanged -> FETCH.
- Watchdog:
  - counts consecutive cycles in FETCH/FWAIT/MEM/MWAIT without the awaited event; clears on every state change.
  - When it reaches TIMEOUT-1 and the event is still absent -> TRAP.
  - Causes: 1 = fetch fault (FETCH/FWAIT), 5 = load fault, 7 = store fault (MEM/MWAIT).
  - If the event arrives in the same cycle the watchdog expires, the event wins.
- cycle_cnt increments every cycle after reset. Both counters wrap modulo 2^CNT_W with no flag.
- Min latency: ALU op 5 cycles, load/store 7 cycles, assuming gnt same cycle and rvalid next cycle.
- Reset mid-transaction: abandon it immediately. The bus must tolerate a dropped req; late rvalid after reset is ignored, since it is only considered in wait states.

Decomposition:
- Shared package `seq_pkg`:
  - state enum (3 bits);
  - cause constants CAUSE_IFAULT=1, CAUSE_ILLEGAL=2, CAUSE_LFAULT=5, CAUSE_SFAULT=7;
  - pc_sel constants PC_NEXT=0, PC_TRAP=1.
- One sub-module `bus_watchdog`:
  - inputs clr, wait_en, event;
  - output expire;
  - parameter TIMEOUT.

Test Plan:
- ALU op, gnt immediate, rvalid +1, dec flags all 0 except dec_rf_wb=1 -> ir_we at cycle 2, rf_we+pc_we at cycle 5, instret_cnt 0->1.
- Load with dmem_gnt delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, rf_we=1 in WB, total 10 cycles.
- Store -> dmem_we=1 with dmem_req, rf_we=0 in WB even with dec_rf_wb=1.
- dec_illegal=1 -> trap pulse in cycle after DECODE, trap_cause=2, pc_sel=1, instret unchanged.
- TIMEOUT=4, imem_gnt never asserted -> trap with cause 1 after 4 FETCH cycles; with gnt on the 4th cycle instead -> no trap, FWAIT.
- Assert rstn=0 during MWAIT -> next cycle all outputs 0, state FETCH, counters 0, imem_req=1 after release.
